// File: rtl/serial_rb_loader.sv
// serial_rb_loader: deserialises addr+data frames from a gated serial port and
// writes each word into a register bank, verifying it by readback with retries.
module serial_rb_loader #(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 18,
    parameter int NUM_WORDS = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sen,
    input  logic              sd,
    input  logic [DATA_W-1:0] rb_q,
    output logic              rb_rw,
    output logic [ADDR_W-1:0] rb_a,
    output logic [DATA_W-1:0] rb_d,
    output logic              done,
    output logic              err,
    output logic              frm_err,
    output logic              ovr
);
    localparam int F  = ADDR_W + DATA_W;
    localparam int BW = $clog2(F);
    localparam int WW = $clog2(NUM_WORDS + 1);
    localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} state_t;

    state_t            state_q, state_d;
    logic [F-2:0]      sh_q, sh_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WW-1:0]     wc_q, wc_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d, frm_err_q, frm_err_d, ovr_q, ovr_d;
    logic [F-1:0]      frame;
    logic              rx_on, frame_ok, chk, match, give_up, last;

    // the frame is assembled from the shift register plus the bit sampled on this edge
    always_comb begin
        frame    = {sh_q, sd};
        rx_on    = state_q != DONE;
        frame_ok = rx_on && !sen && bit_cnt_q == BW'(F - 1);
        chk      = state_q == CHECK;
        match    = rb_q == data_q;
        give_up  = !match && retry_q == RW'(MAX_RETRY);
        last     = wc_q == WW'(NUM_WORDS - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = frame_ok ? WRITE : IDLE;
            WRITE:   state_d = READ;
            READ:    state_d = CHECK;
            CHECK:   state_d = (match || give_up) ? (last ? DONE : IDLE) : WRITE;
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        sh_d      = (rx_on && !sen) ? frame[F-2:0] : sh_q;
        bit_cnt_d = !rx_on ? bit_cnt_q : (sen || frame_ok) ? '0 : bit_cnt_q + 1'b1;
        frm_err_d = frm_err_q | (rx_on && sen && bit_cnt_q != '0);
        ovr_d     = ovr_q | (frame_ok && state_q != IDLE);
        addr_d    = (frame_ok && state_q == IDLE) ? frame[F-1:DATA_W] : addr_q;
        data_d    = (frame_ok && state_q == IDLE) ? frame[DATA_W-1:0] : data_q;
        retry_d   = !chk ? retry_q : (match || give_up) ? '0 : retry_q + 1'b1;
        wc_d      = (chk && (match || give_up)) ? wc_q + 1'b1 : wc_q;
        err_d     = err_q | (chk && give_up);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q      <= '0;
            bit_cnt_q <= '0;
            wc_q      <= '0;
            retry_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
            wc_q      <= wc_d;
            retry_q   <= retry_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            err_q     <= err_d;
            frm_err_q <= frm_err_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        rb_rw   = state_q != WRITE;
        done    = state_q == DONE;
        rb_a    = addr_q;
        rb_d    = data_q;
        err     = err_q;
        frm_err = frm_err_q;
        ovr     = ovr_q;
    end
endmodule

// File: tb/tb_serial_rb_loader.sv
// tb_serial_rb_loader: directed frames into a default-width loader and a narrow
// loader (short frames make overrun reachable), each backed by a bank model.
module tb_serial_rb_loader;
    logic clk = 0, rst = 1, bank_clr = 0;
    logic sen_a = 1, sd_a = 0, sen_b = 1, sd_b = 0;
    logic [17:0] rbq_a, d_a;
    logic [2:0]  a_a;
    logic        rw_a, done_a, err_a, fe_a, ovr_a;
    logic [3:0]  rbq_b, d_b;
    logic [1:0]  a_b;
    logic        rw_b, done_b, err_b, fe_b, ovr_b;
    logic        fail_a = 0, fail_b = 0;
    logic [2:0]  fadr_a = 0;
    logic [1:0]  fadr_b = 0;
    logic [17:0] mem_a [8];
    logic [3:0]  mem_b [4];
    int          wcnt_a [8];
    int          wcnt_b [4];
    int          wtot_a, wtot_b;
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    serial_rb_loader u_a (
        .clk(clk), .rst(rst), .sen(sen_a), .sd(sd_a), .rb_q(rbq_a), .rb_rw(rw_a),
        .rb_a(a_a), .rb_d(d_a), .done(done_a), .err(err_a), .frm_err(fe_a), .ovr(ovr_a)
    );

    serial_rb_loader #(.ADDR_W(2), .DATA_W(4), .NUM_WORDS(4), .MAX_RETRY(2)) u_b (
        .clk(clk), .rst(rst), .sen(sen_b), .sd(sd_b), .rb_q(rbq_b), .rb_rw(rw_b),
        .rb_a(a_b), .rb_d(d_b), .done(done_b), .err(err_b), .frm_err(fe_b), .ovr(ovr_b)
    );

    // banks write on rw=0 and return registered read data one cycle later
    always @(posedge clk) begin
        if (bank_clr) begin
            wtot_a <= 0;
            wtot_b <= 0;
            for (int i = 0; i < 8; i++) wcnt_a[i] <= 0;
            for (int i = 0; i < 4; i++) wcnt_b[i] <= 0;
        end else begin
            if (!rw_a) begin
                mem_a[a_a]  <= d_a;
                wcnt_a[a_a] <= wcnt_a[a_a] + 1;
                wtot_a      <= wtot_a + 1;
            end
            if (!rw_b) begin
                mem_b[a_b]  <= d_b;
                wcnt_b[a_b] <= wcnt_b[a_b] + 1;
                wtot_b      <= wtot_b + 1;
            end
        end
        rbq_a <= (fail_a && a_a == fadr_a) ? '0 : mem_a[a_a];
        rbq_b <= (fail_b && a_b == fadr_b) ? '0 : mem_b[a_b];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_rst();
        rst = 1;
        sen_a = 1;
        sen_b = 1;
        bank_clr = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        bank_clr = 0;
    endtask

    task automatic send_a(input logic [2:0] a, input logic [17:0] d, input int nb);
        logic [20:0] f;
        f = {a, d};
        for (int i = 20; i > 20 - nb; i--) begin
            sen_a = 0;
            sd_a = f[i];
            @(negedge clk);
        end
    endtask

    task automatic send_b(input logic [1:0] a, input logic [3:0] d);
        logic [5:0] f;
        f = {a, d};
        for (int i = 5; i >= 0; i--) begin
            sen_b = 0;
            sd_b = f[i];
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_rst();
        chk("rst rw", rw_a, 1);
        chk("rst a", a_a, 0);
        chk("rst d", d_a, 0);
        chk("rst done", done_a, 0);
        chk("rst err", err_a, 0);
        chk("rst frm_err", fe_a, 0);
        chk("rst ovr", ovr_a, 0);

        send_a(3'b101, 18'h2A5C3, 21);
        sen_a = 1;
        chk("t1 strobe", rw_a, 0);
        chk("t1 addr", a_a, 5);
        chk("t1 data", d_a, 18'h2A5C3);
        repeat (3) @(negedge clk);
        chk("t1 rw idle", rw_a, 1);
        chk("t1 wc", u_a.wc_q, 1);
        chk("t1 done", done_a, 0);
        chk("t1 writes", wtot_a, 1);
        chk("t1 mem", mem_a[5], 18'h2A5C3);

        do_rst();
        for (int i = 0; i < 8; i++) send_a(3'(i), 18'h00001 << i, 21);
        sen_a = 1;
        chk("t2 last strobe", rw_a, 0);
        @(negedge clk);
        chk("t2 done e1", done_a, 0);
        @(negedge clk);
        chk("t2 done e2", done_a, 0);
        @(negedge clk);
        chk("t2 done e3", done_a, 1);
        chk("t2 err", err_a, 0);
        chk("t2 ovr", ovr_a, 0);
        chk("t2 writes", wtot_a, 8);
        chk("t2 mem7", mem_a[7], 18'h00080);
        send_a(3'd1, 18'h3FFFF, 21);
        sen_a = 1;
        repeat (4) @(negedge clk);
        chk("t2 ignored writes", wtot_a, 8);
        chk("t2 ignored ovr", ovr_a, 0);
        chk("t2 rw hold", rw_a, 1);
        chk("t2 a hold", a_a, 7);
        chk("t2 d hold", d_a, 18'h00080);

        do_rst();
        fail_a = 1;
        fadr_a = 3'd2;
        for (int i = 0; i < 8; i++) send_a(3'(i), 18'h00001 << i, 21);
        sen_a = 1;
        for (int i = 0; i < 30 && !done_a; i++) @(negedge clk);
        chk("t3 done", done_a, 1);
        chk("t3 err", err_a, 1);
        chk("t3 ovr", ovr_a, 0);
        chk("t3 tries a2", wcnt_a[2], 3);
        chk("t3 writes", wtot_a, 10);
        fail_a = 0;

        do_rst();
        send_a(3'd1, 18'h12345, 10);
        sen_a = 1;
        @(negedge clk);
        chk("t4 frm_err", fe_a, 1);
        send_a(3'd6, 18'h3C0F0, 21);
        sen_a = 1;
        repeat (4) @(negedge clk);
        chk("t4 writes", wtot_a, 1);
        chk("t4 a1 unwritten", wcnt_a[1], 0);
        chk("t4 mem6", mem_a[6], 18'h3C0F0);
        chk("t4 wc", u_a.wc_q, 1);

        send_a(3'd7, 18'h2AAAA, 21);
        sen_a = 1;
        repeat (3) @(negedge clk);
        send_a(3'd1, 18'h3FFFF, 8);
        sen_a = 1;
        rst = 1;
        #1;
        chk("t6 mid rw", rw_a, 1);
        chk("t6 mid a", a_a, 0);
        chk("t6 mid d", d_a, 0);
        chk("t6 mid frm_err", fe_a, 0);
        chk("t6 mid bitcnt", u_a.bit_cnt_q, 0);
        @(negedge clk);
        rst = 0;
        send_a(3'd2, 18'h0BEEF, 21);
        sen_a = 1;
        chk("t6 strobe", rw_a, 0);
        rst = 1;
        #1;
        chk("t6 wr rw", rw_a, 1);
        chk("t6 wr a", a_a, 0);
        chk("t6 wr d", d_a, 0);
        @(negedge clk);
        rst = 0;
        send_a(3'd4, 18'h15555, 21);
        sen_a = 1;
        chk("t6 new a", a_a, 4);
        chk("t6 new d", d_a, 18'h15555);
        repeat (3) @(negedge clk);
        chk("t6 new wc", u_a.wc_q, 1);
        chk("t6 new mem", mem_a[4], 18'h15555);

        do_rst();
        fail_b = 1;
        fadr_b = 2'd1;
        send_b(2'd1, 4'hA);
        send_b(2'd2, 4'h5);
        sen_b = 1;
        repeat (10) @(negedge clk);
        chk("t5 ovr", ovr_b, 1);
        chk("t5 err", err_b, 1);
        chk("t5 tries a1", wcnt_b[1], 3);
        chk("t5 a2 dropped", wcnt_b[2], 0);
        send_b(2'd3, 4'h3);
        sen_b = 1;
        repeat (4) @(negedge clk);
        chk("t5 wc", u_b.wc_q, 2);
        chk("t5 not done", done_b, 0);
        chk("t5 mem3", mem_b[3], 4'h3);
        send_b(2'd0, 4'h6);
        send_b(2'd2, 4'h9);
        sen_b = 1;
        repeat (4) @(negedge clk);
        chk("t5 done", done_b, 1);
        chk("t5 mem2", mem_b[2], 4'h9);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/serial_rb_loader.md
Name: serial_rb_loader

Overview:
- Parametrised serial-to-register-bank loader. Deserialises address+data frames from a 1-bit serial port gated by `sen`, writes each word into an external register bank, reads it back and verifies it.
- Raises `done` after NUM_WORDS words are verified. Adds width/depth generality, per-write verify with retry, frame-abort detection and overrun detection.
- Sits between the serial host interface and a register bank.

Parameters:
- ADDR_W, 3, register-bank address width in bits.
- DATA_W, 18, register-bank data width in bits.
- NUM_WORDS, 8, number of verified writes before `done` is raised (1..2^ADDR_W·4).
- MAX_RETRY, 2, extra write attempts after a readback mismatch before the word is flagged bad.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sen  in  1  serial enable, active low; a bit is sampled on every rising edge with sen=0.
- sd  in  1  serial data, MSB first.
- rb_q  in  DATA_W  register-bank read data.
- rb_rw  out  1  1=read, 0=write.
- rb_a  out  ADDR_W  register-bank address.
- rb_d  out  DATA_W  register-bank write data.
- done  out  1  sticky; NUM_WORDS words written and verified.
- err  out  1  sticky; some word failed verify after MAX_RETRY retries.
- frm_err  out  1  sticky; a frame was aborted by sen going high mid-frame.
- ovr  out  1  sticky; a frame completed while the write engine was busy, and was dropped.

Behaviour:
- Reset (asynchronous, any time, including mid-frame or mid-write):
  - rb_rw=1; rb_a=0; rb_d=0; done=err=frm_err=ovr=0.
  - Bit counter, word counter and retry counter cleared; engine state IDLE; partial frame discarded.
- Receiver (runs independently of the engine):
  - Frame length is F=ADDR_W+DATA_W bits: first ADDR_W bits are the address, next DATA_W bits are the data, both MSB first.
  - Each edge with sen=0 shifts in sd and increments the bit counter.
  - On the edge that samples bit F, the frame is complete and the bit counter returns to 0. The next bit starts a new frame; back-to-back frames need no gap.
  - sen=1 with bit counter ≠0: partial frame discarded, bit counter returns to 0, frm_err=1.
  - sen=1 with bit counter=0: idle, no effect.
  - Receiver ignores input once done=1.
- Hand-off:
  - Engine in IDLE at the completing edge: addr/data are loaded into rb_a/rb_d, rb_rw=0, and the engine goes to WRITE on that same edge.
  - Engine not in IDLE at the completing edge: frame dropped, ovr=1.
- Engine state machine (one edge per transition):
  - IDLE→WRITE as above.
  - WRITE: rb_rw=0 held one cycle; the bank captures at the next edge. Then rb_rw=1, go to READ.
  - READ: rb_a held, rb_rw=1. The bank presents rb_q one cycle later. Go to CHECK.
  - CHECK: compare rb_q with rb_d.
    - Match: word counter+1, retry counter=0. If word counter reaches NUM_WORDS, go to DONE with done=1; else go to IDLE.
    - Mismatch with retry counter<MAX_RETRY: retry counter+1, rb_rw=0, go to WRITE.
    - Mismatch with retry counter=MAX_RETRY: err=1, retry counter=0, the word counts as processed, then same NUM_WORDS test as on a match.
  - DONE: rb_rw=1; rb_a/rb_d hold the last values; stays until reset.
- Latency: the write strobe (rb_rw=0) is visible the cycle after the last frame bit is sampled; done/idle is reached 3 edges later when there are no retries.
- Word counter width is ceil(log2(NUM_WORDS+1)) bits; it never wraps, because DONE is terminal.
- Repeated addresses are allowed; each frame counts as a separate word.

Test Plan:
- Defaults, one frame addr=3'b101, data=18'h2A5C3, sen=0 for 21 cycles, ideal bank → one write cycle with rb_a=5 and rb_d=18'h2A5C3, then read, check, return to IDLE, word counter=1, done=0.
- 8 back-to-back frames to addresses 0..7, data=18'h00001<<addr, ideal bank → 8 writes, done=1 exactly 3 edges after the last write strobe, err=0, ovr=0, rb_rw=1 thereafter.
- Bank forcing rb_q=0 for address 2 → 3 write attempts (1 + MAX_RETRY), then err=1; the remaining words still complete and done=1.
- sen raised after 10 bits of a frame, then a full valid frame → frm_err=1; only the valid frame is written.
- MAX_RETRY=2 with a failing word and the next frame arriving during the retries → ovr=1, that frame is not written, and the word counter excludes it.
- rst pulsed mid-frame and again during WRITE → all outputs return to reset values immediately; a fresh frame afterwards is received and written correctly.
